// File: rtl/visualizer_frame_sequencer.sv
// rtl/visualizer_frame_sequencer.sv - frame controller: start visualizer, await results, expand bins to LED pixel stream
module visualizer_frame_sequencer #(
  parameter int LEDS         = 50,
  parameter int BIN_QTY      = 12,
  parameter int START_CYCLES = 2,
  parameter int MIN_WAIT     = 4,
  parameter int TIMEOUT      = 1023,
  parameter int CW           = $clog2(LEDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_v_i,
  output logic                  frame_ready_o,
  output logic                  vis_start_o,
  input  logic                  vis_data_v_i,
  input  logic [BIN_QTY*24-1:0] vis_rgb_i,
  input  logic [BIN_QTY*CW-1:0] vis_led_counts_i,
  output logic [23:0]           led_rgb_o,
  output logic                  led_v_o,
  input  logic                  led_ready_i,
  output logic                  led_last_o,
  output logic                  busy_o,
  output logic                  timeout_err_o
);
  localparam int BW   = $clog2(BIN_QTY + 1);
  localparam int WLIM = MIN_WAIT + TIMEOUT - 1;
  localparam int WW   = $clog2(WLIM + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_TOUT, S_STREAM} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         cnt_q, cnt_d;
  logic [BIN_QTY*24-1:0] rgb_q, rgb_d;
  logic [BIN_QTY*CW-1:0] lc_q, lc_d;
  logic [BW-1:0]         bin_q, bin_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [CW-1:0]         px_q, px_d;
  logic                  data_ok, beat, last_px;

  // First bin at or above 'from' with a nonzero count; BIN_QTY selects padding.
  function automatic logic [BW-1:0] next_nz(input logic [BIN_QTY*CW-1:0] c, input int from);
    next_nz = BW'(BIN_QTY);
    for (int j = BIN_QTY - 1; j >= 0; j--)
      if (j >= from && c[j*CW +: CW] != '0) next_nz = BW'(j);
  endfunction

  function automatic logic [CW-1:0] cnt_of(input logic [BIN_QTY*CW-1:0] c, input logic [BW-1:0] b);
    cnt_of = '0;
    for (int j = 0; j < BIN_QTY; j++)
      if (b == BW'(j)) cnt_of = c[j*CW +: CW];
  endfunction

  function automatic logic [23:0] rgb_of(input logic [BIN_QTY*24-1:0] c, input logic [BW-1:0] b);
    rgb_of = '0;
    for (int j = 0; j < BIN_QTY; j++)
      if (b == BW'(j)) rgb_of = c[j*24 +: 24];
  endfunction

  assign data_ok = (state_q == S_WAIT) && (cnt_q >= WW'(MIN_WAIT)) && vis_data_v_i;
  assign beat    = (state_q == S_STREAM) && led_ready_i;
  assign last_px = (px_q == CW'(LEDS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_v_i) state_d = S_START;
      S_START:  if (cnt_q == WW'(START_CYCLES - 1)) state_d = S_WAIT;
      S_WAIT: begin
        if (data_ok)                   state_d = S_STREAM;
        else if (cnt_q == WW'(WLIM))   state_d = S_TOUT;
      end
      S_TOUT:   state_d = S_STREAM;
      S_STREAM: if (beat && last_px) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_ready_o = (state_q == S_IDLE);
    vis_start_o   = (state_q == S_START);
    busy_o        = (state_q != S_IDLE);
    timeout_err_o = (state_q == S_TOUT);
    led_v_o       = (state_q == S_STREAM);
    led_last_o    = (state_q == S_STREAM) && last_px;
    led_rgb_o     = (state_q == S_STREAM) ? rgb_of(rgb_q, bin_q) : 24'h000000;
  end

  // bin_q always points at a nonzero bin (or padding), so zero-count bins cost no beat.
  always_comb begin
    cnt_d = (state_d == state_q && (state_q == S_START || state_q == S_WAIT)) ? cnt_q + 1'b1 : '0;
    rgb_d = rgb_q;
    lc_d  = lc_q;
    bin_d = bin_q;
    rem_d = rem_q;
    px_d  = px_q;
    if (data_ok) begin
      rgb_d = vis_rgb_i;
      lc_d  = vis_led_counts_i;
      bin_d = next_nz(vis_led_counts_i, 0);
      rem_d = cnt_of(vis_led_counts_i, next_nz(vis_led_counts_i, 0));
      px_d  = '0;
    end else if (state_q == S_TOUT) begin
      lc_d  = '0;
      bin_d = BW'(BIN_QTY);
      rem_d = '0;
      px_d  = '0;
    end else if (beat) begin
      px_d = px_q + 1'b1;
      if (bin_q < BW'(BIN_QTY)) begin
        if (rem_q == CW'(1)) begin
          bin_d = next_nz(lc_q, int'(bin_q) + 1);
          rem_d = cnt_of(lc_q, next_nz(lc_q, int'(bin_q) + 1));
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rgb_q <= '0;
      lc_q  <= '0;
      bin_q <= '0;
      rem_q <= '0;
      px_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rgb_q <= rgb_d;
      lc_q  <= lc_d;
      bin_q <= bin_d;
      rem_q <= rem_d;
      px_q  <= px_d;
    end
  end
endmodule

// File: tb/tb_visualizer_frame_sequencer.sv
// tb/tb_visualizer_frame_sequencer.sv - table-driven scoreboard bench for visualizer_frame_sequencer
module tb_visualizer_frame_sequencer;
  localparam int LEDS     = 50;
  localparam int BQ       = 12;
  localparam int CW       = $clog2(LEDS);
  localparam int MIN_WAIT = 4;
  localparam int TIMEOUT  = 1023;
  localparam int NV       = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_v_i, frame_ready_o, vis_start_o, vis_data_v_i;
  logic [BQ*24-1:0]  vis_rgb_i;
  logic [BQ*CW-1:0]  vis_led_counts_i;
  logic [23:0]       led_rgb_o;
  logic              led_v_o, led_ready_i, led_last_o, busy_o, timeout_err_o;

  typedef struct packed {
    logic [BQ-1:0][CW-1:0] cnt;
    logic [BQ-1:0][23:0]   rgb;
    logic                  tmo;
    logic                  rnd;
    logic                  scr;
    int                    exp_black;
    logic [23:0]           exp_last;
  } vec_t;

  vec_t        vecs [NV];
  logic [24:0] exp_q [$];
  int          total, bad;

  always #5 clk = ~clk;

  visualizer_frame_sequencer dut (
    .clk_i(clk), .rst_i(rst), .frame_v_i(frame_v_i), .frame_ready_o(frame_ready_o),
    .vis_start_o(vis_start_o), .vis_data_v_i(vis_data_v_i), .vis_rgb_i(vis_rgb_i),
    .vis_led_counts_i(vis_led_counts_i), .led_rgb_o(led_rgb_o), .led_v_o(led_v_o),
    .led_ready_i(led_ready_i), .led_last_o(led_last_o), .busy_o(busy_o),
    .timeout_err_o(timeout_err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input vec_t v);
    int n;
    n = 0;
    for (int b = 0; b < BQ; b++)
      for (int k = 0; k < int'(v.cnt[b]); k++)
        if (n < LEDS) begin
          exp_q.push_back({n == LEDS - 1, v.rgb[b]});
          n++;
        end
    while (n < LEDS) begin
      exp_q.push_back({n == LEDS - 1, 24'h000000});
      n++;
    end
  endtask

  task automatic stream(input vec_t v, input int stop_at);
    int          beats, cycles, blacks;
    logic [23:0] last_rgb;
    logic [25:0] prev;
    logic        stalled;
    logic [24:0] e;
    beats = 0; cycles = 0; blacks = 0; last_rgb = '0; stalled = 1'b0; prev = '0;
    while (beats < stop_at && cycles < 3000) begin
      if (stalled) check("stall_hold", 32'({led_v_o, led_last_o, led_rgb_o}), 32'(prev));
      led_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (led_v_o && led_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'(beats), 32'(LEDS));
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'({led_last_o, led_rgb_o}), 32'(e));
        end
        if (led_rgb_o == 24'h0) blacks++;
        last_rgb = led_rgb_o;
        beats++;
      end
      stalled = led_v_o && !led_ready_i;
      prev    = {led_v_o, led_last_o, led_rgb_o};
      tick;
      cycles++;
      if (v.scr) begin
        vis_rgb_i        = ~vis_rgb_i;
        vis_led_counts_i = ~vis_led_counts_i;
      end
    end
    led_ready_i = 1'b1;
    check("beats", 32'(beats), 32'(stop_at));
    if (stop_at == LEDS) begin
      if (!v.rnd) check("stream_cycles", 32'(cycles), 32'(LEDS));
      check("black_count", 32'(blacks), 32'(v.exp_black));
      check("last_rgb", 32'(last_rgb), 32'(v.exp_last));
      check("end_frame_ready", 32'(frame_ready_o), 32'd1);
      check("end_busy", 32'(busy_o), 32'd0);
      check("end_led_v", 32'(led_v_o), 32'd0);
    end
  endtask

  task automatic run_frame(input vec_t v, input int stop_at);
    int   n;
    vec_t blk;
    vis_led_counts_i = v.cnt;
    vis_rgb_i        = v.rgb;
    vis_data_v_i     = 1'b0;
    frame_v_i        = 1'b1;
    check("ready_before_accept", 32'(frame_ready_o), 32'd1);
    blk = v;
    if (v.tmo) blk.cnt = '0;
    push_expected(blk);
    tick;
    frame_v_i = 1'b0;
    check("start_hi_1", 32'(vis_start_o), 32'd1);
    check("busy_in_start", 32'(busy_o), 32'd1);
    check("not_ready_in_start", 32'(frame_ready_o), 32'd0);
    tick;
    check("start_hi_2", 32'(vis_start_o), 32'd1);
    tick;
    check("start_fall", 32'(vis_start_o), 32'd0);
    vis_data_v_i = 1'b1;
    if (!v.tmo) begin
      n = 0;
      while (!led_v_o && n < 3000) begin
        tick;
        n++;
      end
      vis_data_v_i = 1'b0;
      check("done_latency", 32'(n), 32'(MIN_WAIT + 1));
    end else begin
      for (int i = 0; i < MIN_WAIT; i++) tick;
      vis_data_v_i = 1'b0;
      n = MIN_WAIT;
      while (!timeout_err_o && n < 3000) begin
        check("no_led_v_in_wait", 32'(led_v_o), 32'd0);
        tick;
        n++;
      end
      check("timeout_delay", 32'(n), 32'(TIMEOUT + MIN_WAIT));
      tick;
      check("timeout_one_cycle", 32'(timeout_err_o), 32'd0);
      check("stream_after_timeout", 32'(led_v_o), 32'd1);
    end
    stream(v, stop_at);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; frame_v_i = 1'b0; vis_data_v_i = 1'b0;
    vis_rgb_i = '0; vis_led_counts_i = '0; led_ready_i = 1'b1;

    for (int i = 0; i < NV; i++) vecs[i] = '0;
    for (int b = 0; b < BQ; b++) begin
      vecs[0].cnt[b] = CW'(4);  vecs[0].rgb[b] = 24'(b + 1);
      vecs[1].rgb[b] = {8'(b * 16 + 1), 8'(200 - b), 8'(b)};
      vecs[2].cnt[b] = CW'(6);  vecs[2].rgb[b] = 24'(b + 1);
      vecs[4].cnt[b] = CW'(4);  vecs[4].rgb[b] = 24'(b + 1);
      vecs[5].rgb[b] = 24'(b + 16);
      vecs[6].cnt[b] = CW'(5);  vecs[6].rgb[b] = 24'(b + 1);
    end
    vecs[0].exp_black = 2;  vecs[0].exp_last = 24'h0;
    vecs[1].cnt[1] = CW'(7); vecs[1].cnt[11] = CW'(3);
    vecs[1].exp_black = 40; vecs[1].exp_last = 24'h0;
    vecs[2].exp_black = 0;  vecs[2].exp_last = 24'd9;
    vecs[3] = vecs[0];      vecs[3].rnd = 1'b1; vecs[3].scr = 1'b1;
    vecs[4].cnt[11] = CW'(6);
    vecs[4].exp_black = 0;  vecs[4].exp_last = 24'd12;
    vecs[5].cnt[0] = CW'(63); vecs[5].cnt[3] = CW'(2); vecs[5].rnd = 1'b1;
    vecs[5].exp_black = 0;  vecs[5].exp_last = 24'd16;
    vecs[6].tmo = 1'b1;     vecs[6].exp_black = 50; vecs[6].exp_last = 24'h0;

    tick; tick;
    rst = 1'b0;
    check("rst_frame_ready", 32'(frame_ready_o), 32'd1);
    check("rst_vis_start", 32'(vis_start_o), 32'd0);
    check("rst_led_v", 32'(led_v_o), 32'd0);
    check("rst_led_last", 32'(led_last_o), 32'd0);
    check("rst_led_rgb", 32'(led_rgb_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_timeout_err", 32'(timeout_err_o), 32'd0);
    tick;

    for (int i = 0; i < NV; i++) run_frame(vecs[i], LEDS);

    run_frame(vecs[0], 20);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_led_v", 32'(led_v_o), 32'd0);
    check("midrst_frame_ready", 32'(frame_ready_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    tick;
    run_frame(vecs[1], LEDS);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/visualizer_frame_sequencer.md
# visualizer_frame_sequencer

Frame-level controller for the linear LED visualizer datapath. It accepts one note frame at a time from the upstream note source, then drives the visualizer's start input. It waits, with a timeout, for the visualizer's completion flag and captures the per-bin colors and LED counts. It then expands them into a serial stream of exactly LEDS pixel words for the LED strip driver, using a valid/ready handshake.

## Interface
- LEDS, 50: LEDs per strip; exactly this many pixels are emitted per frame.
- BIN_QTY, 12: number of note bins / color bins.
- START_CYCLES, 2: cycles vis_start is held high per frame (≥2, because the visualizer pipelines note capture).
- MIN_WAIT, 4: cycles after vis_start falls during which vis_data_v is ignored (masks a stale done from the prior frame).
- TIMEOUT, 1023: maximum WAIT cycles before the frame is abandoned.
- Derived: CW = $clog2(LEDS).
- Clock and reset:
  - clk  in  1  sole clock; all state updates on posedge.
  - rst  in  1  synchronous, active-high reset.
- Upstream frame handshake:
  - frame_v  in  1  upstream notes are valid and stable.
  - frame_ready  out  1  sequencer can accept a frame.
- Visualizer side:
  - vis_start  out  1  start strobe to the visualizer.
  - vis_data_v  in  1  visualizer results valid.
  - vis_rgb  in  BIN_QTY×24  per-bin color, {R,G,B}.
  - vis_ledCounts  in  BIN_QTY×CW  per-bin LED count.
- LED strip side:
  - led_rgb  out  24  pixel color.
  - led_v  out  1  pixel valid.
  - led_ready  in  1  strip driver accepts the pixel.
  - led_last  out  1  marks pixel LEDS-1.
- Status:
  - busy  out  1  high in any state other than IDLE.
  - timeout_err  out  1  one-cycle pulse on timeout.

## Operation
- States:
  - IDLE: frame_ready=1.
    - frame_v && frame_ready moves to START.
  - START: vis_start=1 for START_CYCLES cycles, then WAIT.
  - WAIT:
    - The first MIN_WAIT cycles ignore vis_data_v.
    - After that, vis_data_v=1 captures vis_rgb and vis_ledCounts into internal registers, then goes to STREAM.
    - If the wait counter reaches TIMEOUT with no done: pulse timeout_err, load all captured counts as 0, go to STREAM (emits an all-black frame).
  - STREAM: emits pixels; after the handshake on the last pixel, goes to IDLE.
- Expansion order:
  - Bin 0 first. Bin b contributes ledCounts[b] pixels of rgb[b].
  - Zero-count bins are skipped with no idle bubble. A zero-count bin must not cost a beat; bin advance is combinational lookahead or a skip in the same cycle.
  - If the sum of counts < LEDS, the remaining pixels are 24'h000000.
  - If the sum > LEDS, output truncates at pixel LEDS-1; later bins are dropped.
- Counters:
  - Pixel index: 0..LEDS-1.
  - Bin index: 0..BIN_QTY. BIN_QTY means padding.
  - Per-bin remaining count: CW bits.
- Captured data:
  - Held in registers, so vis_* inputs may change during STREAM without effect.
- frame_v outside IDLE is ignored. It is not queued.
- The frame handshake is complete on the single cycle it occurs. Upstream must hold notes stable until frame_ready rises again.

## Timing
- Reset values:
  - State IDLE, all counters 0.
  - frame_ready=1, vis_start=0, led_v=0, led_last=0, led_rgb=0, busy=0, timeout_err=0.
- Reset asserted mid-frame returns to IDLE on the next edge. No partial pixels follow. led_v is 0 the cycle after rst.
- Accept at edge T: vis_start is high on cycles T+1 .. T+START_CYCLES.
- Done latency: vis_data_v sampled at edge E (valid window) gives led_v=1 with pixel 0 from cycle E+1.
- A beat completes on an edge with led_v && led_ready.
  - While led_v && !led_ready: led_rgb, led_last and led_v hold constant.
- With led_ready tied high, STREAM lasts exactly LEDS cycles.
- The last beat completes at edge L: frame_ready=1 and busy=0 from cycle L+1. A new frame can be accepted at edge L+1.
- Timeout: timeout_err is high for exactly the one cycle after the edge where the counter hits TIMEOUT. STREAM starts the following cycle.
- Simultaneous vis_data_v and timeout on the same edge: data wins, no timeout_err.

## Test plan
- All 12 counts = 4, rgb[b] = b+1, led_ready=1:
  - Expect 48 pixels of values 1..12, four each, then 2 pixels of 0.
  - led_last on pixel 49.
  - frame_ready returns 50 cycles after the first led_v.
- Counts {0,7,0,…,0,3}, rest 0:
  - Expect 7× rgb[1], 3× rgb[11], 40× black.
  - No gap cycles while led_ready=1.
- All counts = 6 (sum 72):
  - Expect 6 pixels each for bins 0..7, then 2 of bin 8, for 50 total.
  - Bins 9..11 absent; led_last on pixel 49.
- Random led_ready (≈50% duty), plus vis_rgb changed during STREAM:
  - Pixel sequence is identical to the led_ready=1 case.
  - Outputs hold while stalled; captured data is unaffected.
- vis_data_v never asserted:
  - timeout_err pulses once, TIMEOUT+MIN_WAIT cycles after vis_start falls.
  - Then 50 black pixels, then IDLE.
  - vis_data_v=1 inside the MIN_WAIT window is ignored.
- rst asserted at pixel 20 of a frame:
  - Next cycle: led_v=0, frame_ready=1, busy=0.
  - A new frame then streams from pixel 0 correctly.
